// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
package forwarding_hazard_unit_pkg;

    localparam int REG_BITS = 5;
    localparam logic [REG_BITS-1:0] ZERO_REG = 5'd31;

    // ALU operand mux selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Full tag of the instruction sitting in ID/EX
    typedef struct packed {
        logic [REG_BITS-1:0] rn;
        logic [REG_BITS-1:0] rm;
        logic                rm_used;
        logic [REG_BITS-1:0] rd;
        logic                regwrite;
        logic                memread;
    } tag_t;

    // Producer tag in EX/MEM and MEM/WB: only the destination matters there
    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic                regwrite;
    } prod_t;

    localparam tag_t TAG_BUBBLE = '{rn: 5'd0, rm: 5'd0, rm_used: 1'b0,
                                    rd: 5'd0, regwrite: 1'b0, memread: 1'b0};

    localparam prod_t PROD_BUBBLE = '{rd: 5'd0, regwrite: 1'b0};

    // Strip an ID/EX tag down to its producer view
    function automatic prod_t to_prod(input tag_t t);
        prod_t p;
        p.rd       = t.rd;
        p.regwrite = t.regwrite;
        return p;
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Decode-side inputs and hazard outputs of the forwarding unit.
interface forwarding_hazard_unit_if
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);
    logic [REG_BITS-1:0]  ID_Rn;
    logic [REG_BITS-1:0]  ID_Rm;
    logic [REG_BITS-1:0]  ID_Rd;
    logic                 ID_RegWrite;
    logic                 ID_MemRead;
    logic                 ID_UsesRm;
    logic                 Flush;
    logic [1:0]           ForwardA;
    logic [1:0]           ForwardB;
    logic                 Stall;
    logic [CNT_WIDTH-1:0] StallCount;

    // Pipeline / decode side
    modport master (
        output ID_Rn, ID_Rm, ID_Rd, ID_RegWrite, ID_MemRead, ID_UsesRm, Flush,
        input  ForwardA, ForwardB, Stall, StallCount
    );

    // Hazard unit side
    modport slave (
        input  ID_Rn, ID_Rm, ID_Rd, ID_RegWrite, ID_MemRead, ID_UsesRm, Flush,
        output ForwardA, ForwardB, Stall, StallCount
    );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// One operand's forward select: EX/MEM producer beats MEM/WB, XZR never forwards.
module fwd_select
    import forwarding_hazard_unit_pkg::*;
(
    input  logic [REG_BITS-1:0] src_i,
    input  logic                src_used_i,
    input  prod_t               exmem_i,
    input  prod_t               memwb_i,
    output logic [1:0]          sel_o
);

    // Priority compare against the two in-flight producers
    always_comb begin
        sel_o = FWD_REG;
        if (!src_used_i) begin
            sel_o = FWD_REG;
        end else if (exmem_i.regwrite && (exmem_i.rd == src_i) && (exmem_i.rd != ZERO_REG)) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_i.regwrite && (memwb_i.rd == src_i) && (memwb_i.rd != ZERO_REG)) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_REG;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Shadow tag pipeline driving ALU forward selects and the load-use stall.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
)(
    input  logic                      CLOCK,
    input  logic                      RESET_n,
    forwarding_hazard_unit_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    tag_t                 idex_q,  idex_d;
    prod_t                exmem_q, exmem_d;
    prod_t                memwb_q, memwb_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 stall_s;
    logic [1:0]           fwd_a_s;
    logic [1:0]           fwd_b_s;
    tag_t                 decode_s;

    // Load in ID/EX whose destination is read by the instruction in decode; a flush kills it
    always_comb begin
        stall_s = 1'b0;
        if (bus.Flush) begin
            stall_s = 1'b0;
        end else if (idex_q.memread && (idex_q.rd != ZERO_REG) &&
                     ((idex_q.rd == bus.ID_Rn) ||
                      (bus.ID_UsesRm && (idex_q.rd == bus.ID_Rm)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next-state of the tag pipeline and the saturating stall counter
    always_comb begin
        decode_s.rn       = bus.ID_Rn;
        decode_s.rm       = bus.ID_Rm;
        decode_s.rm_used  = bus.ID_UsesRm;
        decode_s.rd       = bus.ID_Rd;
        decode_s.regwrite = bus.ID_RegWrite;
        decode_s.memread  = bus.ID_MemRead;

        exmem_d = to_prod(idex_q);
        memwb_d = exmem_q;

        if (bus.Flush || stall_s) begin
            idex_d = TAG_BUBBLE;
        end else begin
            idex_d = decode_s;
        end

        if (stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLOCK) begin
        if (!RESET_n) begin
            idex_q  <= TAG_BUBBLE;
            exmem_q <= PROD_BUBBLE;
            memwb_q <= PROD_BUBBLE;
            cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .src_i      (idex_q.rn),
        .src_used_i (1'b1),
        .exmem_i    (exmem_q),
        .memwb_i    (memwb_q),
        .sel_o      (fwd_a_s)
    );

    fwd_select u_fwd_b (
        .src_i      (idex_q.rm),
        .src_used_i (idex_q.rm_used),
        .exmem_i    (exmem_q),
        .memwb_i    (memwb_q),
        .sel_o      (fwd_b_s)
    );

    assign bus.ForwardA   = fwd_a_s;
    assign bus.ForwardB   = fwd_b_s;
    assign bus.Stall      = stall_s;
    assign bus.StallCount = cnt_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit; a 4-bit-counter twin checks saturation.
module tb_forwarding_hazard_unit;
    import forwarding_hazard_unit_pkg::*;

    logic CLOCK;
    logic RESET_n;
    int   checks;
    int   errors;

    forwarding_hazard_unit_if #(.CNT_WIDTH(16)) bus ();
    forwarding_hazard_unit_if #(.CNT_WIDTH(4))  bus4 ();

    forwarding_hazard_unit #(.CNT_WIDTH(16)) dut (
        .CLOCK   (CLOCK),
        .RESET_n (RESET_n),
        .bus     (bus.slave)
    );

    forwarding_hazard_unit #(.CNT_WIDTH(4)) dut4 (
        .CLOCK   (CLOCK),
        .RESET_n (RESET_n),
        .bus     (bus4.slave)
    );

    assign bus4.ID_Rn       = bus.ID_Rn;
    assign bus4.ID_Rm       = bus.ID_Rm;
    assign bus4.ID_Rd       = bus.ID_Rd;
    assign bus4.ID_RegWrite = bus.ID_RegWrite;
    assign bus4.ID_MemRead  = bus.ID_MemRead;
    assign bus4.ID_UsesRm   = bus.ID_UsesRm;
    assign bus4.Flush       = bus.Flush;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic used);
        bus.ID_Rn       = rn;
        bus.ID_Rm       = rm;
        bus.ID_Rd       = rd;
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.ID_UsesRm   = used;
        #1;
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET_n  = 1'b0;
        bus.Flush = 1'b0;
        nop();
        tick();
        tick();
        RESET_n = 1'b1;
        #1;
        check("rst_fwda", {14'd0, bus.ForwardA}, 16'h0);
        check("rst_fwdb", {14'd0, bus.ForwardB}, 16'h0);
        check("rst_stall", {15'd0, bus.Stall}, 16'h0);
        check("rst_cnt", bus.StallCount, 16'h0);

        // ADD X1,X2,X3 ; SUB X2,X1,X3
        set_id(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd1, 5'd3, 5'd2, 1'b1, 1'b0, 1'b1);
        check("alu_no_stall", {15'd0, bus.Stall}, 16'h0);
        tick();
        check("exmem_fwda", {14'd0, bus.ForwardA}, 16'h2);
        check("exmem_fwdb", {14'd0, bus.ForwardB}, 16'h0);

        // ADD X1 ; NOP ; ORR X4,X5,X1
        set_id(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b1);
        tick();
        nop();
        tick();
        set_id(5'd5, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        check("memwb_fwdb", {14'd0, bus.ForwardB}, 16'h1);
        check("memwb_fwda", {14'd0, bus.ForwardA}, 16'h0);

        // ADD X1 ; ADD X1,X6,X7 ; ORR X4,X5,X1 -> newest producer wins
        set_id(5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd6, 5'd7, 5'd1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd5, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        check("prio_fwdb", {14'd0, bus.ForwardB}, 16'h2);
        check("prio_fwda", {14'd0, bus.ForwardA}, 16'h0);

        // LDUR X7,[X10] ; ADD X8,X7,X9
        set_id(5'd10, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd7, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1);
        check("lu_stall", {15'd0, bus.Stall}, 16'h1);
        tick();
        check("lu_stall_drop", {15'd0, bus.Stall}, 16'h0);
        check("lu_bubble_fwda", {14'd0, bus.ForwardA}, 16'h0);
        check("lu_cnt1", bus.StallCount, 16'h1);
        tick();
        check("lu_fwda", {14'd0, bus.ForwardA}, 16'h1);
        check("lu_fwdb", {14'd0, bus.ForwardB}, 16'h0);
        check("lu_cnt_hold", bus.StallCount, 16'h1);

        // X31 is never a forwarding source
        set_id(5'd2, 5'd3, 5'd31, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd31, 5'd31, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        check("xzr_fwda", {14'd0, bus.ForwardA}, 16'h0);
        check("xzr_fwdb", {14'd0, bus.ForwardB}, 16'h0);
        set_id(5'd10, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd31, 5'd31, 5'd5, 1'b1, 1'b0, 1'b1);
        check("xzr_no_stall", {15'd0, bus.Stall}, 16'h0);
        // ADD X12 ; ADDI X13,X14 with stale Rm=X12
        set_id(5'd2, 5'd3, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd14, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        check("imm_fwdb", {14'd0, bus.ForwardB}, 16'h0);
        check("imm_fwda", {14'd0, bus.ForwardA}, 16'h0);

        // Load-use with a coincident flush
        set_id(5'd10, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd7, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1);
        bus.Flush = 1'b1;
        #1;
        check("flush_stall", {15'd0, bus.Stall}, 16'h0);
        tick();
        bus.Flush = 1'b0;
        #1;
        check("flush_bubbled", {15'd0, bus.Stall}, 16'h0);
        check("flush_cnt", bus.StallCount, 16'h1);
        tick();

        // Back-to-back loads to X7, each stalls once
        set_id(5'd10, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        check("b2b_stall1", {15'd0, bus.Stall}, 16'h1);
        tick();
        check("b2b_drop1", {15'd0, bus.Stall}, 16'h0);
        tick();
        set_id(5'd7, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1);
        check("b2b_stall2", {15'd0, bus.Stall}, 16'h1);
        tick();
        check("b2b_drop2", {15'd0, bus.Stall}, 16'h0);
        check("b2b_cnt", bus.StallCount, 16'h3);
        tick();

        // Reset during a stall cycle
        set_id(5'd10, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd7, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1);
        check("rs_stall", {15'd0, bus.Stall}, 16'h1);
        RESET_n = 1'b0;
        tick();
        RESET_n = 1'b1;
        #1;
        check("rs_stall_off", {15'd0, bus.Stall}, 16'h0);
        check("rs_fwda", {14'd0, bus.ForwardA}, 16'h0);
        check("rs_fwdb", {14'd0, bus.ForwardB}, 16'h0);
        check("rs_cnt", bus.StallCount, 16'h0);
        check("rs_cnt4", {12'd0, bus4.StallCount}, 16'h0);

        // 17 load-use stalls: wide counter counts, 4-bit twin pins at all-ones
        for (int i = 0; i < 17; i++) begin
            set_id(5'd10, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
            tick();
            set_id(5'd7, 5'd9, 5'd8, 1'b1, 1'b0, 1'b1);
            tick();
            tick();
        end
        check("sat_cnt16", bus.StallCount, 16'd17);
        check("sat_cnt4", {12'd0, bus4.StallCount}, 16'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
